// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/bubble sequencing, operand forwarding selects and stall counter for a 5-stage core
// Ports: clk/rst_n (sync active-low); ID sources IDRq/IDRs with use flags and IDHalt;
// EX dest EXRd with EXRegWrite/EXMemRead/EXMulStart; MEM dest MEMRd with MEMRegWrite; branch flush.
// Outputs: PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble (combinational),
// FwdA/FwdB (00 regfile, 01 EX/MEM, 10 MEM/WB), Halted, StallCycles (registered).
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  IDRq,
  input  logic [3:0]  IDRs,
  input  logic        IDUsesRq,
  input  logic        IDUsesRs,
  input  logic        IDHalt,
  input  logic [3:0]  EXRd,
  input  logic        EXRegWrite,
  input  logic        EXMemRead,
  input  logic        EXMulStart,
  input  logic [3:0]  MEMRd,
  input  logic        MEMRegWrite,
  input  logic        flush,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXWrite,
  output logic        IDEXBubble,
  output logic        EXMEMBubble,
  output logic [1:0]  FwdA,
  output logic [1:0]  FwdB,
  output logic        Halted,
  output logic [15:0] StallCycles
);
  typedef enum logic [1:0] {S_RUN, S_MULBUSY, S_HALT} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic halted_q, load_use;
  logic [15:0] stall_q;
  assign load_use = EXMemRead && EXRegWrite && EXRd != 4'd0 &&
                    ((IDUsesRq && IDRq == EXRd) || (IDUsesRs && IDRs == EXRd));
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [3:0] src);
    return (!uses || src == 4'd0) ? 2'b00 :
           (EXRegWrite && EXRd == src) ? 2'b01 :
           (MEMRegWrite && MEMRd == src) ? 2'b10 : 2'b00;
  endfunction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (!flush && EXMulStart) begin
          state_d = S_MULBUSY;
          cnt_d   = 4'(MULT_CYCLES - 1);
        end else if (!flush && !load_use && IDHalt) begin
          state_d = S_HALT;
        end
      end
      S_MULBUSY: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q <= 4'd1) ? S_RUN : S_MULBUSY;
      end
      default: state_d = S_HALT;
    endcase
  end
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    EXMEMBubble = 1'b0;
    case (state_q)
      S_RUN: begin
        if (flush) begin
          IFIDFlush  = 1'b1;
          IDEXBubble = 1'b1;
        end else if (EXMulStart) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMBubble = 1'b1;
        end else if (load_use) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end
      end
      S_MULBUSY: begin
        // last busy cycle (cnt==1) lets the pipeline advance with the op result
        if (cnt_q > 4'd1) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMBubble = 1'b1;
        end
      end
      default: begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b1;
      end
    endcase
  end
  // selects follow the ID/EX register: hold on stall, clear on bubble
  always_comb begin
    fwd_a_d = !IDEXWrite ? fwd_a_q : IDEXBubble ? 2'b00 : fwd_sel(IDUsesRq, IDRq);
    fwd_b_d = !IDEXWrite ? fwd_b_q : IDEXBubble ? 2'b00 : fwd_sel(IDUsesRs, IDRs);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_a_q  <= 2'b00;
      fwd_b_q  <= 2'b00;
      halted_q <= 1'b0;
      stall_q  <= 16'd0;
    end else begin
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      halted_q <= state_d == S_HALT;
      if (!PCWrite && state_q != S_HALT && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end
  assign FwdA        = fwd_a_q;
  assign FwdB        = fwd_b_q;
  assign Halted      = halted_q;
  assign StallCycles = stall_q;
endmodule
